neuron_mac: RTL and testbench



---
 rtl/neuron_mac.sv | 110 +++++++++++
 tb/tb_neuron_mac.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Streaming multiply-accumulate neuron: N_TERMS Q8.8 products, plus a bias, narrowed to a saturated Q8.8 result.
// Define MAC_ROUND_EN to round half up before narrowing; the default build truncates toward -inf.
module neuron_mac #(
    parameter int                 N_TERMS = 4,
    parameter int                 ACC_W   = 40,
    parameter logic signed [15:0] BIAS    = 16'sh0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_x,
    output logic        out_sat
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);
    // Bias moved from Q8.8 into the Q16.16 accumulator domain.
    localparam logic signed [ACC_W-1:0] BIAS_Q16 = {{(ACC_W-24){BIAS[15]}}, BIAS, 8'h00};

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  sum_adj;
    logic signed [ACC_W-1:0]  r;
    logic                     accept;
    logic                     last;
    logic                     clip;
    logic [15:0]              x_sat;

    assign accept   = in_valid & in_ready;
    assign last     = (cnt == CNT_LAST);
    assign prod     = $signed(in_x) * $signed(in_w);
    assign prod_ext = ACC_W'(prod);
    assign sum      = acc + prod_ext + BIAS_Q16;

`ifdef MAC_ROUND_EN
    assign sum_adj  = sum + ACC_W'(128);
`else
    assign sum_adj  = sum;
`endif

    assign r = sum_adj >>> 8;

    // r fits in 16 bits only when everything from bit 15 upward is a copy of the sign.
    assign clip  = !((&r[ACC_W-1:15]) | (~|r[ACC_W-1:15]));
    assign x_sat = clip ? (r[ACC_W-1] ? 16'h8000 : 16'h7FFF) : r[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (accept && last) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            out_x   <= 16'h0000;
            out_sat <= 1'b0;
        end else if (accept) begin
            if (last) begin
                cnt     <= '0;
                acc     <= '0;
                out_x   <= x_sat;
                out_sat <= clip;
            end else begin
                cnt <= cnt + 1'b1;
                acc <= acc + prod_ext;
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: default build plus a second instance with a -1.0 bias.
// Expected rounding results follow MAC_ROUND_EN the same way the design does.
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic        out_sat;

    logic        in_ready_b;
    logic        out_valid_b;
    logic [15:0] out_x_b;
    logic        out_sat_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    neuron_mac dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_sat   (out_sat)
    );

    neuron_mac #(.BIAS(16'shFF00)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .in_x      (in_x),
        .in_w      (in_w),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .out_x     (out_x_b),
        .out_sat   (out_sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [15:0] x, input logic [15:0] w, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_x     = 16'hDEAD;
            in_w     = 16'hBEEF;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("beat_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
    endtask

    // Call immediately after the last beat: checks one-cycle latency and the result.
    task automatic result(input string tag, input logic [15:0] ex, input logic es);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(out_valid), 32'd1);
        chk({tag, "_x"}, 32'(out_x), 32'(ex));
        chk({tag, "_sat"}, 32'(out_sat), 32'(es));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run4(input string tag, input logic [15:0] x, input logic [15:0] w,
                        input logic [15:0] ex, input logic es);
        for (int i = 0; i < 4; i++) beat(x, w, 0);
        result(tag, ex, es);
        consume(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = 16'h0000;
        in_w      = 16'h0000;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_x", 32'(out_x), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        rst = 1'b0;

        // 4 x (1.0*1.0) = 4.0; biased instance sees 3.0
        for (int i = 0; i < 4; i++) beat(16'h0100, 16'h0100, 0);
        result("ones", 16'h0400, 1'b0);
        chk("bias_x", 32'(out_x_b), 32'h0300);
        chk("bias_sat", 32'(out_sat_b), 32'd0);
        consume("ones");

        run4("neg", 16'hFE00, 16'h0180, 16'hF400, 1'b0);
        run4("pos_sat", 16'h7F00, 16'h7F00, 16'h7FFF, 1'b1);

        // Negative saturation, held under back-pressure with junk on the input side
        for (int i = 0; i < 4; i++) beat(16'h8000, 16'h7F00, 0);
        result("neg_sat", 16'h8000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_x     = 16'h1234;
            in_w     = 16'h5678;
            @(negedge clk);
            chk("bp_x", 32'(out_x), 32'h8000);
            chk("bp_sat", 32'(out_sat), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        consume("bp");

        // Half-LSB rounding cases
        beat(16'h0001, 16'h0080, 0);
        for (int i = 0; i < 3; i++) beat(16'h0000, 16'h0000, 0);
`ifdef MAC_ROUND_EN
        result("rnd_pos", 16'h0001, 1'b0);
`else
        result("rnd_pos", 16'h0000, 1'b0);
`endif
        consume("rnd_pos");
        beat(16'hFFFF, 16'h0080, 0);
        for (int i = 0; i < 3; i++) beat(16'h0000, 16'h0000, 0);
`ifdef MAC_ROUND_EN
        result("rnd_neg", 16'h0000, 1'b0);
`else
        result("rnd_neg", 16'hFFFF, 1'b0);
`endif
        consume("rnd_neg");

        // Reset mid-evaluation discards the partial sum
        beat(16'h0100, 16'h0100, 0);
        beat(16'h0100, 16'h0100, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        run4("midrst", 16'h0200, 16'h0100, 16'h0800, 1'b0);

        // Same evaluation with 3-cycle gaps between beats
        for (int i = 0; i < 4; i++) beat(16'h0200, 16'h0100, 3);
        result("gaps", 16'h0800, 1'b0);
        consume("gaps");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
